// File: rtl/unit_output_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unit_output_arbiter_pkg
//  Description : Shared definitions for the unit output arbiter: FSM state
//                encodings, header length field position and the compile-time
//                checksum switch derived from UNIT_OUTPUT_CHECKSUM_EN.
//  Macro       : UNIT_OUTPUT_CHECKSUM_EN (defined -> trailing checksum word)
//  Revision    : 1.0  initial release
// ============================================================================
package unit_output_arbiter_pkg;

  // Most significant bit of the payload length field inside the header word.
  localparam int HDR_LEN_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

`ifdef UNIT_OUTPUT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

endpackage : unit_output_arbiter_pkg
`default_nettype wire

// File: rtl/unit_output_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational round-robin priority encoder. Searches the
//                request vector starting one position after 'last', wrapping
//                modulo N_UNITS, and returns the first requester found.
//  Ports       : req       - request vector, one bit per unit
//                last      - index of the most recently served unit
//                grant_num - index of the selected unit (valid when any=1)
//                any       - at least one request is present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_select #(
  parameter int N_UNITS = 4,
  parameter int SEL_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic [N_UNITS-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   grant_num,
  output logic               any
);

  int w_idx;

  // Walk from the farthest candidate back to the nearest one so that the
  // closest requester after 'last' is the final (winning) assignment.
  always_comb begin
    grant_num = '0;
    w_idx     = 0;
    for (int k = N_UNITS; k >= 1; k--) begin
      w_idx = int'(last) + k;
      if (w_idx >= N_UNITS) begin
        w_idx = w_idx - N_UNITS;
      end
      if (req[SEL_W'(w_idx)]) begin
        grant_num = SEL_W'(w_idx);
      end
    end
  end

  assign any = |req;

endmodule : rr_select
`default_nettype wire

// File: rtl/unit_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unit_output_arbiter
//  Description : Merges result packets from N_UNITS first-word-fall-through
//                unit output buffers into one registered valid/ready stream.
//                Units are served round-robin; packets (header with length in
//                bits [7:0] followed by that many payload words) are forwarded
//                whole and never interleaved.
//  Macro       : UNIT_OUTPUT_CHECKSUM_EN - when defined, each packet is
//                followed by one word holding the modulo-2^WIDTH sum of its
//                header and payload words.
//  Ports       : CLK, RST_N   - clock, synchronous active-low reset
//                unit_dout    - per-unit data, unit i at [WIDTH*i +: WIDTH]
//                unit_empty   - per-unit empty flag
//                unit_rd_en   - per-unit read strobe (one-hot or zero)
//                out_data     - merged stream word (registered)
//                out_valid    - out_data holds a word
//                out_ready    - downstream accepts the word
//                busy         - a packet is in progress
//  Revision    : 1.0  initial release
// ============================================================================
module unit_output_arbiter
  import unit_output_arbiter_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH*N_UNITS-1:0] unit_dout,
  input  logic [N_UNITS-1:0]       unit_empty,
  output logic [N_UNITS-1:0]       unit_rd_en,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int                c_SEL_W     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [c_SEL_W-1:0] c_LAST_INIT = c_SEL_W'(N_UNITS - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_SEL_W-1:0]     r_sel;
  logic [c_SEL_W-1:0]     r_last;
  logic [c_SEL_W-1:0]     w_grant;
  logic                   w_any;
  logic [N_UNITS-1:0]     w_req;
  logic [HDR_LEN_MSB:0]   r_cnt;
  logic [HDR_LEN_MSB:0]   w_hdr_len;
  logic [WIDTH-1:0]       r_out_data;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       w_src_data;
  logic [WIDTH-1:0]       w_load_data;
  logic                   w_src_ready;
  logic                   w_slot_free;
  logic                   w_mv;
  logic                   w_csum_mv;
  logic                   w_load;
  logic                   w_pkt_end;

  assign w_req = ~unit_empty;

  rr_select #(
    .N_UNITS (N_UNITS),
    .SEL_W   (c_SEL_W)
  ) u_rr_select (
    .req       (w_req),
    .last      (r_last),
    .grant_num (w_grant),
    .any       (w_any)
  );

  assign w_src_data  = unit_dout[int'(r_sel)*WIDTH +: WIDTH];
  assign w_src_ready = ~unit_empty[r_sel];
  assign w_hdr_len   = w_src_data[HDR_LEN_MSB:0];

  // The output register can take a word when empty or being drained now.
  assign w_slot_free = ~r_out_valid | out_ready;

  // Gated by RST_N so no upstream word is popped while reset is asserted.
  assign w_mv = RST_N & w_src_ready & w_slot_free &
                ((r_state == ST_HDR) | (r_state == ST_DATA));

  assign w_pkt_end = w_mv & (((r_state == ST_HDR)  & (w_hdr_len == '0)) |
                             ((r_state == ST_DATA) & (r_cnt == 8'd1)));

`ifdef UNIT_OUTPUT_CHECKSUM_EN
  logic [WIDTH-1:0] r_acc;

  always_ff @(posedge CLK) begin
    if (!RST_N || r_state == ST_IDLE) begin
      r_acc <= '0;
    end else if (w_mv) begin
      r_acc <= r_acc + w_src_data;
    end
  end

  assign w_csum_mv   = RST_N & (r_state == ST_CSUM) & w_slot_free;
  assign w_load_data = (r_state == ST_CSUM) ? r_acc : w_src_data;
`else
  assign w_csum_mv   = 1'b0;
  assign w_load_data = w_src_data;
`endif

  assign w_load = w_mv | w_csum_mv;

  // Next state and read strobe.
  always_comb begin
    w_state_nxt = r_state;
    unit_rd_en  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR, ST_DATA: begin
        unit_rd_en[r_sel] = w_mv;
        if (w_pkt_end) begin
          w_state_nxt = CSUM_EN ? ST_CSUM : ST_IDLE;
        end else if (w_mv && r_state == ST_HDR) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (w_slot_free) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_last      <= c_LAST_INIT;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_IDLE && w_any) begin
        r_sel <= w_grant;
      end

      if (w_pkt_end) begin
        r_last <= r_sel;
      end

      if (w_mv) begin
        if (r_state == ST_HDR) begin
          r_cnt <= w_hdr_len;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
      end

      // A load wins over an accept, so load+accept keeps valid high.
      if (w_load) begin
        r_out_data  <= w_load_data;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);

endmodule : unit_output_arbiter
`default_nettype wire

// File: tb/tb_unit_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unit_output_arbiter
//  Description : Directed, table-driven bench for unit_output_arbiter. A small
//                first-word-fall-through buffer model feeds each unit input;
//                every table row either pushes a word into a unit buffer or
//                runs one clock cycle and compares the outputs against
//                hand-computed values. Reset and checksum cases are written
//                out as explicit sequences.
//  Macro       : UNIT_OUTPUT_CHECKSUM_EN selects the checksum sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_unit_output_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [W*N-1:0] unit_dout;
  logic [N-1:0]   unit_empty;
  logic [N-1:0]   unit_rd_en;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  unit_output_arbiter #(
    .N_UNITS (N),
    .WIDTH   (W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .unit_dout  (unit_dout),
    .unit_empty (unit_empty),
    .unit_rd_en (unit_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_push;
    int          unit;
    logic [15:0] word;
    bit          rdy;
    logic [3:0]  hold;
    logic [3:0]  e_rd;
    bit          e_v;
    logic [15:0] e_d;
    bit          e_b;
  } row_t;

  row_t tbl[$];

  logic [15:0] mem [N][32];
  logic [4:0]  rp  [N];
  logic [4:0]  wp  [N];
  logic [N-1:0] hold;

  logic [N-1:0] s_rd;
  logic         s_v;
  logic [15:0]  s_d;
  logic         s_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      unit_empty[i]       = (rp[i] == wp[i]) || hold[i];
      unit_dout[i*W +: W] = mem[i][rp[i]];
    end
  endtask

  task automatic push(input int u, input logic [15:0] w);
    mem[u][wp[u]] = w;
    wp[u] = wp[u] + 5'd1;
    refresh();
  endtask

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge CLK);
    s_rd = unit_rd_en;
    s_v  = out_valid;
    s_d  = out_data;
    s_b  = busy;
  endtask

  // Pops the buffers that were strobed in the sampled cycle.
  task automatic advance();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_rd[i] && rp[i] != wp[i]) begin
        rp[i] = rp[i] + 5'd1;
      end
    end
    refresh();
  endtask

  task automatic cyc(input string tag, input bit rdy, input logic [3:0] hmask,
                     input logic [3:0] e_rd, input bit e_v,
                     input logic [15:0] e_d, input bit e_b);
    out_ready = rdy;
    hold      = hmask;
    refresh();
    sample();
    check(tag, "unit_rd_en", 32'(s_rd), 32'(e_rd));
    check(tag, "out_valid",  32'(s_v),  32'(e_v));
    check(tag, "busy",       32'(s_b),  32'(e_b));
    if (e_v) begin
      check(tag, "out_data", 32'(s_d), 32'(e_d));
    end
    advance();
  endtask

  function automatic void add_push(input int u, input logic [15:0] w);
    row_t r;
    r.is_push = 1'b1; r.unit = u; r.word = w;
    r.rdy = 1'b1; r.hold = '0; r.e_rd = '0; r.e_v = 1'b0; r.e_d = '0; r.e_b = 1'b0;
    tbl.push_back(r);
  endfunction

  function automatic void add_cyc(input bit rdy, input logic [3:0] hm,
                                  input logic [3:0] rd, input bit v,
                                  input logic [15:0] d, input bit b);
    row_t r;
    r.is_push = 1'b0; r.unit = 0; r.word = '0;
    r.rdy = rdy; r.hold = hm; r.e_rd = rd; r.e_v = v; r.e_d = d; r.e_b = b;
    tbl.push_back(r);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rp[i] = '0;
      wp[i] = '0;
      for (int j = 0; j < 32; j++) mem[i][j] = '0;
    end
    hold      = '0;
    out_ready = 1'b1;
    RST_N     = 1'b0;
    refresh();

    // Reset state.
    sample();
    check("reset", "unit_rd_en", 32'(s_rd), 32'h0);
    check("reset", "out_valid",  32'(s_v),  32'h0);
    check("reset", "out_data",   32'(s_d),  32'h0);
    check("reset", "busy",       32'(s_b),  32'h0);
    advance();
    RST_N = 1'b1;

`ifdef UNIT_OUTPUT_CHECKSUM_EN
    // Header 0x0002, payload 0xFFFF,0x0003 -> checksum 0x0004.
    push(0, 16'h0002); push(0, 16'hFFFF); push(0, 16'h0003);
    cyc("cs0", 1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    cyc("cs1", 1, 4'b0000, 4'b0001, 0, 16'h0000, 1);
    cyc("cs2", 1, 4'b0000, 4'b0001, 1, 16'h0002, 1);
    cyc("cs3", 1, 4'b0000, 4'b0001, 1, 16'hFFFF, 1);
    cyc("cs4", 1, 4'b0000, 4'b0000, 1, 16'h0003, 1);
    cyc("cs5", 1, 4'b0000, 4'b0000, 1, 16'h0004, 0);
    cyc("cs6", 1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
`else
    // Single packet from unit 0.
    add_push(0, 16'h1203); add_push(0, 16'h000A); add_push(0, 16'h000B); add_push(0, 16'h000C);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    add_cyc(1, 4'b0000, 4'b0001, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h1203, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h000A, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h000B, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h000C, 0);
    // Units 1 and 3 competing, then unit 0 preferred over unit 1.
    add_push(1, 16'h0102); add_push(1, 16'h1111); add_push(1, 16'h1112);
    add_push(3, 16'h0302); add_push(3, 16'h3331); add_push(3, 16'h3332);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    add_cyc(1, 4'b0000, 4'b0010, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0010, 1, 16'h0102, 1);
    add_cyc(1, 4'b0000, 4'b0010, 1, 16'h1111, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h1112, 0);
    add_cyc(1, 4'b0000, 4'b1000, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b1000, 1, 16'h0302, 1);
    add_cyc(1, 4'b0000, 4'b1000, 1, 16'h3331, 1);
    add_push(0, 16'h0001); add_push(0, 16'h0A0A);
    add_push(1, 16'h0101); add_push(1, 16'h1B1B);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h3332, 0);
    add_cyc(1, 4'b0000, 4'b0001, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h0001, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h0A0A, 0);
    add_cyc(1, 4'b0000, 4'b0010, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0010, 1, 16'h0101, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h1B1B, 0);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    // Zero-length packet from unit 2.
    add_push(2, 16'h5500);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    add_cyc(1, 4'b0000, 4'b0100, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h5500, 0);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    // Backpressure 1,0,0,1 during an L=4 packet from unit 3.
    add_push(3, 16'h0004); add_push(3, 16'h4441); add_push(3, 16'h4442);
    add_push(3, 16'h4443); add_push(3, 16'h4444);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    add_cyc(1, 4'b0000, 4'b1000, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b1000, 1, 16'h0004, 1);
    add_cyc(0, 4'b0000, 4'b0000, 1, 16'h4441, 1);
    add_cyc(0, 4'b0000, 4'b0000, 1, 16'h4441, 1);
    add_cyc(1, 4'b0000, 4'b1000, 1, 16'h4441, 1);
    add_cyc(1, 4'b0000, 4'b1000, 1, 16'h4442, 1);
    add_cyc(1, 4'b0000, 4'b1000, 1, 16'h4443, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h4444, 0);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    // Unit 0 runs dry after 2 of 5 payload words for 10 cycles; unit 1 waits.
    add_push(0, 16'h0005); add_push(0, 16'h5001); add_push(0, 16'h5002);
    add_push(0, 16'h5003); add_push(0, 16'h5004); add_push(0, 16'h5005);
    add_push(1, 16'h0100);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    add_cyc(1, 4'b0000, 4'b0001, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h0005, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h5001, 1);
    add_cyc(1, 4'b0001, 4'b0000, 1, 16'h5002, 1);
    for (int k = 0; k < 9; k++) add_cyc(1, 4'b0001, 4'b0000, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0001, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h5003, 1);
    add_cyc(1, 4'b0000, 4'b0001, 1, 16'h5004, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h5005, 0);
    add_cyc(1, 4'b0000, 4'b0010, 0, 16'h0000, 1);
    add_cyc(1, 4'b0000, 4'b0000, 1, 16'h0100, 0);
    add_cyc(1, 4'b0000, 4'b0000, 0, 16'h0000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_push) begin
        push(tbl[i].unit, tbl[i].word);
      end else begin
        cyc($sformatf("row%0d", i), tbl[i].rdy, tbl[i].hold, tbl[i].e_rd,
            tbl[i].e_v, tbl[i].e_d, tbl[i].e_b);
      end
    end

    // Reset pulse in the middle of a unit 2 packet.
    push(2, 16'h0003); push(2, 16'h6661); push(2, 16'h6662); push(2, 16'h6663);
    cyc("rst0", 1, 4'b0000, 4'b0000, 0, 16'h0000, 0);
    cyc("rst1", 1, 4'b0000, 4'b0100, 0, 16'h0000, 1);
    cyc("rst2", 1, 4'b0000, 4'b0100, 1, 16'h0003, 1);
    cyc("rst3", 1, 4'b0000, 4'b0100, 1, 16'h6661, 1);
    RST_N = 1'b0;
    cyc("rst4", 1, 4'b0000, 4'b0000, 1, 16'h6662, 1);
    RST_N = 1'b1;
    out_ready = 1'b1;
    hold      = 4'b0100;
    refresh();
    sample();
    check("rst5", "unit_rd_en", 32'(s_rd), 32'h0);
    check("rst5", "out_valid",  32'(s_v),  32'h0);
    check("rst5", "out_data",   32'(s_d),  32'h0);
    check("rst5", "busy",       32'(s_b),  32'h0);
    advance();
    cyc("rst6", 1, 4'b0100, 4'b0000, 0, 16'h0000, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_unit_output_arbiter
`default_nettype wire
